debounce_pulse_gen: RTL and testbench

//  Upstream conditioning stage for the synchronous T-FF up-counter's `en` input.

---
 rtl/debounce_pulse_gen_pkg.sv | 28 ++
 rtl/debounce_pulse_gen_bit_synchronizer.sv | 26 ++
 rtl/debounce_pulse_gen.sv | 155 +++++++++++++++
 tb/tb_debounce_pulse_gen.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pulse_gen_pkg.sv
// Shared definitions for the push-button conditioning path: FSM state
// encodings, default parameter values and counter sizing helpers.
// Optional feature macro used by importers: AUTO_REPEAT_EN.
package debounce_pulse_gen_pkg;

  // 2-bit encodings are fixed so status taps and other input blocks agree.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_DELAY    = 16;
  localparam int DEF_REPEAT_PERIOD   = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter must hold the largest terminal value any state compares against.
  function automatic int cnt_width(input int deb, input int rd, input int rp);
    return $clog2(max_int(max_int(deb, rd), rp) + 1);
  endfunction

endpackage

// File: rtl/debounce_pulse_gen_bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous level into clk.
// Latency: STAGES cycles from input sample to q.
// No handshake; q follows d continuously, cleared by synchronous reset.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // Shift chain; only the last flop is used downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/debounce_pulse_gen.sv
// Button conditioner: synchronise, debounce, one-cycle en_pulse per accepted press.
// Latency: en_pulse/btn_stable change SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after input.
// No backpressure; macro AUTO_REPEAT_EN adds held-button auto-repeat pulses.
module debounce_pulse_gen
  import debounce_pulse_gen_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic en_pulse,
  output logic btn_stable
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

  // The wait states enter with cnt=1 (the sample that triggered the entry), so
  // acceptance happens on the edge where cnt has reached DEBOUNCE_CYCLES; this
  // gives the documented SYNC_STAGES+DEBOUNCE_CYCLES+1 edge latency and a
  // single-cycle wait state when DEBOUNCE_CYCLES=1.
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_END  = CNT_W'(DEBOUNCE_CYCLES);

  logic             btn_sync;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             stable_nxt;
  logic             pulse_nxt;

`ifdef AUTO_REPEAT_EN
  // cnt counts held cycles in PRESSED; first terminal is the initial delay,
  // afterwards the repeat period. Pulse fires on the cycle cnt hits terminal.
  localparam logic [CNT_W-1:0] RD_END = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_END = CNT_W'(REPEAT_PERIOD - 1);

  logic rep_phase;
  logic rep_phase_nxt;
`endif

  // Saturating increment: cnt never wraps even if a terminal is missed.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  bit_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (btn_in),
    .q    (btn_sync)
  );

  // Next-state, counter and output decode; the FSM sees only btn_sync.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    stable_nxt = btn_stable;
    pulse_nxt  = 1'b0;
`ifdef AUTO_REPEAT_EN
    rep_phase_nxt = rep_phase;
`endif
    case (state)
      IDLE: begin
        if (btn_sync) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          // Press bounce: drop back silently.
          state_nxt = IDLE;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt == DEB_END) begin
          state_nxt  = PRESSED;
          stable_nxt = 1'b1;
          pulse_nxt  = 1'b1;
          cnt_nxt    = CNT_ZERO;
`ifdef AUTO_REPEAT_EN
          rep_phase_nxt = 1'b0;
`endif
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          // Release takes priority over any repeat due on this edge.
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = CNT_ONE;
        end else begin
`ifdef AUTO_REPEAT_EN
          if (cnt == (rep_phase ? RP_END : RD_END)) begin
            pulse_nxt     = 1'b1;
            cnt_nxt       = CNT_ZERO;
            rep_phase_nxt = 1'b1;
          end else begin
            cnt_nxt = sat_inc(cnt);
          end
`endif
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync) begin
          // Release bounce: back to held, repeat timing restarts.
          state_nxt = PRESSED;
          cnt_nxt   = CNT_ZERO;
`ifdef AUTO_REPEAT_EN
          rep_phase_nxt = 1'b0;
`endif
        end else if (cnt == DEB_END) begin
          state_nxt  = IDLE;
          stable_nxt = 1'b0;
          cnt_nxt    = CNT_ZERO;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and registered outputs; reset wins and suppresses any pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= CNT_ZERO;
      btn_stable <= 1'b0;
      en_pulse   <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_phase  <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      btn_stable <= stable_nxt;
      en_pulse   <= pulse_nxt;
`ifdef AUTO_REPEAT_EN
      rep_phase  <= rep_phase_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_debounce_pulse_gen.sv
// Directed and random bench for debounce_pulse_gen with a run-length reference model.
// Edge numbers in directed steps count from the first edge of each step.
// Repeat expectations follow AUTO_REPEAT_EN when the bench is built with it.
module tb_debounce_pulse_gen;

  localparam int SS  = 2;
  localparam int DEB = 4;
  localparam int RD  = 16;
  localparam int RP  = 4;

  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic en_pulse;
  logic btn_stable;

  int total = 0;
  int bad   = 0;

  // bookkeeping
  int   edge_no;
  int   pq[$];
  int   chg_edge;
  logic prev_stable;
  logic prev_pulse;
  int   up_count;

  // reference model: synchroniser delay line + run length of samples
  // disagreeing with the debounced level + age since the button became held
  logic sh[SS];
  logic m_stable;
  int   m_run;
  int   m_age;
  logic m_pulse;

  debounce_pulse_gen #(
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .en_pulse  (en_pulse),
    .btn_stable(btn_stable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic b, input logic r);
    logic s;
    s = sh[SS-1];
    for (int i = SS - 1; i > 0; i--) sh[i] = sh[i-1];
    sh[0]   = b;
    m_pulse = 1'b0;
    if (r) begin
      for (int i = 0; i < SS; i++) sh[i] = 1'b0;
      m_stable = 1'b0;
      m_run    = 0;
      m_age    = -1;
      return;
    end
    if (s != m_stable) begin
      // a new level is accepted once DEB+1 consecutive samples agree
      m_run++;
      if (m_run == DEB + 1) begin
        m_stable = s;
        m_run    = 0;
        m_pulse  = s;
        m_age    = s ? 0 : -1;
      end
    end else begin
      if (m_stable) begin
        if (m_run > 0) m_age = 0;
        else if (m_age >= 0) begin
          m_age++;
`ifdef AUTO_REPEAT_EN
          if (m_age >= RD && ((m_age - RD) % RP) == 0) m_pulse = 1'b1;
`endif
        end
      end
      m_run = 0;
    end
  endtask

  task automatic tick(input logic b, input logic r);
    btn_in = b;
    reset  = r;
    @(posedge clk);
    model_step(b, r);
    edge_no++;
    #1;
    if (en_pulse === 1'b1) begin
      pq.push_back(edge_no);
      up_count++;
      chk("pulse_gap", {31'b0, prev_pulse}, 32'd0);
    end
    if (btn_stable !== prev_stable) chg_edge = edge_no;
    prev_stable = btn_stable;
    prev_pulse  = en_pulse;
    chk("en_pulse_vs_model", {31'b0, en_pulse}, {31'b0, m_pulse});
    chk("btn_stable_vs_model", {31'b0, btn_stable}, {31'b0, m_stable});
  endtask

  task automatic start_step();
    edge_no  = 0;
    chg_edge = -1;
    pq.delete();
  endtask

  function automatic int first_pulse();
    return (pq.size() > 0) ? pq[0] : -1;
  endfunction

  initial begin
    int exp_rep[$];
    int cnt_before;
    int lvl;
    int len;

    btn_in      = 1'b0;
    reset       = 1'b1;
    prev_stable = 1'b0;
    prev_pulse  = 1'b0;
    up_count    = 0;
    m_stable    = 1'b0;
    m_run       = 0;
    m_age       = -1;
    for (int i = 0; i < SS; i++) sh[i] = 1'b0;
    start_step();

    // 1. reset held with button pressed
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1);
      chk("reset_en_pulse", {31'b0, en_pulse}, 32'd0);
      chk("reset_btn_stable", {31'b0, btn_stable}, 32'd0);
    end
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);

    // 2. clean press held 20 cycles, then clean release
    start_step();
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
    chk("press_pulse_count", pq.size(), 32'd1);
    chk("press_pulse_edge", first_pulse(), 32'd7);
    chk("press_stable_edge", chg_edge, 32'd7);
    start_step();
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);
    chk("release_stable_edge", chg_edge, 32'd7);
    chk("release_no_pulse", pq.size(), 32'd0);

    // 3. press bounce 1,0,1,0 then steady 1
    start_step();
    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b0);
    chk("bounce_pulse_count", pq.size(), 32'd1);
    chk("bounce_pulse_edge", first_pulse(), 32'd11);

    // 4. release bounce from PRESSED, then clean release
    start_step();
    tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
    chk("relbounce_stable", {31'b0, btn_stable}, 32'd1);
    chk("relbounce_no_pulse", pq.size(), 32'd0);
    chk("relbounce_no_change", chg_edge, 32'hFFFF_FFFF);
    start_step();
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
    chk("clean_release_edge", chg_edge, 32'd7);

    // 5. reset while debouncing a press, then a fresh press
    start_step();
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk("midreset_en_pulse", {31'b0, en_pulse}, 32'd0);
    chk("midreset_btn_stable", {31'b0, btn_stable}, 32'd0);
    chk("midreset_no_pulse", pq.size(), 32'd0);
    start_step();
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
    chk("fresh_pulse_count", pq.size(), 32'd1);
    chk("fresh_pulse_edge", first_pulse(), 32'd7);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);

    // 6. long hold drives the upstream counter
    start_step();
    cnt_before = up_count;
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);
`ifdef AUTO_REPEAT_EN
    exp_rep = '{7, 23, 27, 31, 35, 39};
`else
    exp_rep = '{7};
`endif
    chk("hold_count_advance", up_count - cnt_before, exp_rep.size());
    for (int i = 0; i < exp_rep.size(); i++)
      chk("hold_pulse_edge", (i < pq.size()) ? pq[i] : -1, exp_rep[i]);

    // 7. random bouncy traffic with occasional resets
    for (int k = 0; k < 120; k++) begin
      lvl = $urandom_range(0, 1);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 24);
      for (int i = 0; i < len; i++)
        tick(lvl[0], ($urandom_range(0, 199) == 0));
    end
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);
    chk("final_idle_stable", {31'b0, btn_stable}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
